// File: rtl/char_pkg.sv
// Shared types and constants for the character UART transmit path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package char_pkg;

    localparam int CHAR_W    = 8;
    localparam int DATA_BITS = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous circular FIFO holding bytes waiting to be serialized.
// Latency: a pushed entry is visible on rdata/count after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module char_fifo
    import char_pkg::*;
#(
    parameter int WIDTH = CHAR_W,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/char_uart_tx.sv
// Buffers converted bytes and serializes them as UART 8N1 frames, LSB first.
// Latency: byte accepted at edge k into idle block -> start bit drives tx after edge k+1.
// Backpressure: in_ready drops only while the FIFO holds FIFO_DEPTH bytes.
module char_uart_tx
    import char_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHAR_W-1:0]                 in_char,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [CHAR_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CHAR_W-1:0] head;
    logic              baud_last;

    // Ready depends on registered occupancy only, so a same-cycle pop never frees a full FIFO.
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign baud_last = (baud_q == BAUD_LAST);
    assign tx        = tx_q;

    char_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_char),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register: FSM, baud/bit counters, shift register and the tx flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: advance through the frame one baud period at a time.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = head;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) state_d = STOP;
                    else                   bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued frames are contiguous.
                    if (pop) begin
                        state_d = START;
                        shift_d = head;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pop request, busy flag, and the value the tx flop loads at the next edge.
    always_comb begin
        pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
        busy = (state_q != IDLE) || (fifo_count != '0);
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

endmodule
